serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder built around a single instance of the team's FA full-adder cell, with a registered carry.
- Adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock, under a start/busy/done handshake.
- Sits next to the FA cell as the sequential datapath that feeds it one bit pair per cycle and consumes its Sum/Cout outputs.
- Serves as the area-minimal alternative to the ripple-carry adder in the ALU experiments.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request to begin an addition; sampled on clock edges only.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- sum  output  WIDTH  result; updated only on the completion edge.
- cout  output  1  carry-out of the MSB.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum, cout and overflow become valid.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: while rst_n=0 at an edge, the following are all cleared to 0:
  - state to IDLE;
  - sum, cout, overflow, busy, done;
  - internal shift registers, carry flip-flop and bit counter.
- Reset has priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 loads shA<=a, shB<=b and carry<=cin, clears the counter, and moves to RUN (busy=1 from the next cycle).
  - start=0 stays in IDLE.
- RUN, at each edge:
  - the FA computes s = shA[0]^shB[0]^carry and c = majority(shA[0], shB[0], carry);
  - carry<=c;
  - the result shift register shifts right, inserting s at the MSB;
  - shA and shB shift right;
  - the counter increments.
- Bit 0 is processed at edge E1, bit i at edge E(i+1).
- Completion at edge EWIDTH:
  - sum<=final result (including the bit computed on that edge);
  - cout<=c from the MSB step;
  - overflow<=(carry into MSB) XOR c, using the carry register value at that step;
  - state goes to DONE, busy<=0, done<=1.
- Latency: done is high in the cycle after the WIDTH-th edge following E0, i.e. WIDTH cycles after the start edge.
- DONE lasts one cycle; done=1, busy=0.
  - start=1 here is accepted exactly as from IDLE: operands load, state goes to RUN, done<=0.
  - Otherwise state goes to IDLE and done<=0.
- start in RUN is ignored; operands and progress are unaffected, and no queueing occurs.
- Changes on a/b/cin after acceptance have no effect.
- sum, cout and overflow hold their last values through IDLE and the next RUN until the next completion edge; no partial results are visible.
- Reset mid-RUN: the operation is aborted, no done pulse is produced, and outputs are cleared as at reset.
- busy and done are never both 1.
- The counter is sized to hold WIDTH. Wrap-around is impossible because the counter is cleared on every accept.

Test Plan (WIDTH=8):
- a=0x0F, b=0x01, cin=0, start pulsed at E0 -> busy high for 8 cycles; done high exactly one cycle after E8; sum=0x10, cout=0, overflow=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0; a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, overflow=0.
- a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1; a=0x80, b=0x80 -> sum=0x00, cout=1, overflow=1.
- Start 3+4; at cycle 3 drive start=1 with a=0xAA and change a/b -> sum=0x07 at done; no second done follows.
- Start held high continuously -> back-to-back operations with a done pulse every 9 cycles; a start sampled in DONE is accepted on that edge.
- rst_n=0 at cycle 4 of a run -> next cycle all outputs 0 and state IDLE; no done pulse; a subsequent 0x12+0x34 yields sum=0x46.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one FA cell plus a registered carry, adding two WIDTH-bit
// operands LSB first under a start/busy/done handshake.

module FA (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_shA;
   logic [WIDTH-1:0] r_shB;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_faSum;
   logic             w_faCout;
   logic [WIDTH-1:0] w_nextRes;

   FA u_fa (
      .i_a    (r_shA[0]),
      .i_b    (r_shB[0]),
      .i_cin  (r_carry),
      .o_sum  (w_faSum),
      .o_cout (w_faCout)
   );

   // Result bits enter at the MSB so that after WIDTH steps bit 0 sits at the LSB.
   assign w_nextRes = {w_faSum, r_res[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_shA    <= '0;
         r_shB    <= '0;
         r_res    <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  r_shA   <= a;
                  r_shB   <= b;
                  r_carry <= cin;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_carry <= w_faCout;
               r_res   <= w_nextRes;
               r_shA   <= r_shA >> 1;
               r_shB   <= r_shB >> 1;
               r_cnt   <= r_cnt + 1'b1;
               // On the MSB step the carry register still holds the carry into the MSB.
               if (r_cnt == LAST) begin
                  sum      <= w_nextRes;
                  cout     <= w_faCout;
                  overflow <= r_carry ^ w_faCout;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  r_state  <= DONE;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed and random additions
// compared against a plain-arithmetic reference model.

module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;
   logic         busy;
   logic         done;

   int vectors     = 0;
   int miscompares = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: whole-word addition; overflow when like-signed operands give an unlike-signed result.
   function automatic void model(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opC,
                                 output logic [W-1:0] s, output logic co, output logic ov);
      logic [W:0] full;
      full = {1'b0, opA} + {1'b0, opB} + {{W{1'b0}}, opC};
      s    = full[W-1:0];
      co   = full[W];
      ov   = (opA[W-1] == opB[W-1]) && (s[W-1] != opA[W-1]);
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Launches one addition and waits (bounded) for done; returns observations only.
   task automatic run_op(input logic [W-1:0] opA, input logic [W-1:0] opB, input logic opC,
                         output logic [W-1:0] gotSum, output logic gotCout, output logic gotOvf,
                         output int lat, output int busyCnt, output bit clean);
      logic [W-1:0] holdSum;
      logic         holdCout;
      logic         holdOvf;
      clean   = 1'b1;
      lat     = -1;
      busyCnt = 0;
      gotSum  = 'x;
      gotCout = 1'bx;
      gotOvf  = 1'bx;
      a = opA; b = opB; cin = opC; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      holdSum = sum; holdCout = cout; holdOvf = overflow;
      for (int k = 0; k < 40; k++) begin
         if (busy && done) clean = 1'b0;
         if (done) begin
            lat = k; gotSum = sum; gotCout = cout; gotOvf = overflow;
            break;
         end
         if (busy) busyCnt++;
         if (sum !== holdSum || cout !== holdCout || overflow !== holdOvf) clean = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b1;
      idle(3);
      vectors++; if (sum !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_sum: got %h expected 00", sum); end
      vectors++; if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      start = 1'b0; rst_n = 1'b1;
      idle(2);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_directed();
      logic [W-1:0] tA[5]   = '{8'h0F, 8'hFF, 8'h00, 8'h7F, 8'h80};
      logic [W-1:0] tB[5]   = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h80};
      logic         tC[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [W-1:0] tS[5]   = '{8'h10, 8'h00, 8'h01, 8'h80, 8'h00};
      logic         tCo[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic         tOv[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] gs;
      logic         gc, go;
      int           lat, bc;
      bit           cl;
      for (int i = 0; i < 5; i++) begin
         run_op(tA[i], tB[i], tC[i], gs, gc, go, lat, bc, cl);
         vectors++; if (gs !== tS[i]) begin miscompares++; $display("[TB] FAIL dir%0d_sum: got %h expected %h", i, gs, tS[i]); end
         vectors++; if (gc !== tCo[i]) begin miscompares++; $display("[TB] FAIL dir%0d_cout: got %b expected %b", i, gc, tCo[i]); end
         vectors++; if (go !== tOv[i]) begin miscompares++; $display("[TB] FAIL dir%0d_ovf: got %b expected %b", i, go, tOv[i]); end
         vectors++; if (lat != W) begin miscompares++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, W); end
         vectors++; if (bc != W) begin miscompares++; $display("[TB] FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, W); end
         vectors++; if (!cl) begin miscompares++; $display("[TB] FAIL dir%0d_hold_excl: got 0 expected 1", i); end
         idle(1);
         vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL dir%0d_done_width: got %b expected 0", i, done); end
         idle(1);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] opA, opB, gs, es;
      logic         opC, gc, go, ec, eo;
      int           lat, bc;
      bit           cl;
      for (int i = 0; i < 24; i++) begin
         opA = W'($urandom); opB = W'($urandom); opC = 1'($urandom);
         model(opA, opB, opC, es, ec, eo);
         run_op(opA, opB, opC, gs, gc, go, lat, bc, cl);
         vectors++; if (gs !== es || gc !== ec || go !== eo)
            begin miscompares++; $display("[TB] FAIL rand_result %h+%h+%b: got %h/%b/%b expected %h/%b/%b", opA, opB, opC, gs, gc, go, es, ec, eo); end
         vectors++; if (lat != W || !cl) begin miscompares++; $display("[TB] FAIL rand_timing: got lat %0d clean %0d expected %0d/1", lat, cl, W); end
         idle(i % 3);
      end
   endtask

   task automatic test_ignore_start();
      int lat = -1;
      int extra = 0;
      a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      for (int k = 0; k < 40; k++) begin
         if (done) begin lat = k; break; end
         if (k == 2) begin start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; end
         else start = 1'b0;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      vectors++; if (lat != W) begin miscompares++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, W); end
      vectors++; if (sum !== 8'h07 || cout !== 1'b0 || overflow !== 1'b0)
         begin miscompares++; $display("[TB] FAIL ignore_result: got %h/%b/%b expected 07/0/0", sum, cout, overflow); end
      for (int k = 0; k < 20; k++) begin
         idle(1);
         if (done || busy) extra++;
      end
      vectors++; if (extra != 0) begin miscompares++; $display("[TB] FAIL ignore_no_second: got %0d active cycles expected 0", extra); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] expS[$];
      logic         expC[$];
      logic         expO[$];
      logic [W-1:0] es;
      logic         ec, eo;
      int           lastDone = -1;
      int           nDone = 0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      model(a, b, cin, es, ec, eo);
      expS.push_back(es); expC.push_back(ec); expO.push_back(eo);
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (done) begin
            es = expS.pop_front(); ec = expC.pop_front(); eo = expO.pop_front();
            vectors++; if (sum !== es || cout !== ec || overflow !== eo)
               begin miscompares++; $display("[TB] FAIL b2b_result%0d: got %h/%b/%b expected %h/%b/%b", nDone, sum, cout, overflow, es, ec, eo); end
            if (lastDone >= 0) begin
               vectors++; if (cyc - lastDone != W + 1)
                  begin miscompares++; $display("[TB] FAIL b2b_period%0d: got %0d expected %0d", nDone, cyc - lastDone, W + 1); end
            end
            lastDone = cyc;
            nDone++;
            if (nDone == 4) begin start = 1'b0; break; end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            model(a, b, cin, es, ec, eo);
            expS.push_back(es); expC.push_back(ec); expO.push_back(eo);
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      vectors++; if (nDone != 4) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected 4", nDone); end
      idle(2);
   endtask

   task automatic test_reset_midrun();
      logic [W-1:0] gs;
      logic         gc, go;
      int           lat, bc;
      bit           cl;
      int           stray = 0;
      run_op(8'h21, 8'h43, 1'b0, gs, gc, go, lat, bc, cl);
      vectors++; if (gs !== 8'h64) begin miscompares++; $display("[TB] FAIL pre_reset_sum: got %h expected 64", gs); end
      idle(2);
      a = 8'h55; b = 8'h22; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      idle(3);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      vectors++; if (sum !== 8'h00 || cout !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         begin miscompares++; $display("[TB] FAIL midrun_reset: got %h/%b/%b/%b/%b expected 00/0/0/0/0", sum, cout, overflow, busy, done); end
      for (int k = 0; k < 12; k++) begin
         idle(1);
         if (done || busy) stray++;
      end
      vectors++; if (stray != 0) begin miscompares++; $display("[TB] FAIL midrun_no_done: got %0d active cycles expected 0", stray); end
      run_op(8'h12, 8'h34, 1'b0, gs, gc, go, lat, bc, cl);
      vectors++; if (gs !== 8'h46 || gc !== 1'b0 || go !== 1'b0)
         begin miscompares++; $display("[TB] FAIL post_reset_result: got %h/%b/%b expected 46/0/0", gs, gc, go); end
      vectors++; if (lat != W) begin miscompares++; $display("[TB] FAIL post_reset_latency: got %0d expected %0d", lat, W); end
      idle(2);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #1;
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
